uart_tx_buffered: RTL



---
 rtl/uart_tx_buffered.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed by a small byte FIFO.
// Optional even parity (8E1) when UART_TX_PARITY_EN is defined.
module uart_tx_buffered #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BIT_MAX = CLKS_PER_BIT - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd5
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_d, active_d, done_d;
    logic             bit_end_c;
    logic             push_c, pop_c;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    // FIFO occupancy bookkeeping; a write while full is ignored.
    always_comb begin
        push_c  = i_Tx_DV && (count_q < CNT_W'(FIFO_DEPTH));
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since pointers gate all reads.
    always_ff @(posedge i_Clock) begin
        if (push_c) begin
            mem[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // FIFO pointers, count and the not-full flag.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            o_Tx_Ready <= 1'b1;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            o_Tx_Ready <= (count_d < CNT_W'(FIFO_DEPTH));
        end
    end

    // Frame sequencer: next state, bit timing and next line value.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = o_Tx_Serial;
        pop_c     = 1'b0;
        bit_end_c = (clk_cnt_q == 16'(BIT_MAX));

        case (state_q)
            S_IDLE: begin
                serial_d  = 1'b1;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (count_q != '0) begin
                    pop_c    = 1'b1;
                    shift_d  = mem[rd_ptr_q];
                    serial_d = 1'b0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    serial_d  = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q != 3'd7) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[bit_idx_q + 3'd1];
                    end else begin
`ifdef UART_TX_PARITY_EN
                        serial_d = ^shift_q;
                        state_d  = S_PARITY;
`else
                        serial_d = 1'b1;
                        state_d  = S_STOP;
`endif
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    serial_d  = 1'b1;
                    state_d   = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    serial_d  = 1'b1;
                    state_d   = S_CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_CLEANUP: begin
                serial_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                serial_d  = 1'b1;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = S_IDLE;
            end
        endcase

        active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP)
`ifdef UART_TX_PARITY_EN
                   || (state_d == S_PARITY)
`endif
                   ;
        done_d = (state_d == S_CLEANUP);
    end

    // Sequencer state and registered line outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            o_Tx_Serial <= serial_d;
            o_Tx_Active <= active_d;
            o_Tx_Done   <= done_d;
        end
    end

endmodule
